// File: rtl/bram_stream_if.sv
// Handshake bundle for bram_stream: write, read-request and read-response channels.
interface bram_stream_if #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int BC = 1
);
  // write channel
  logic          write_valid;
  logic          write_ready;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [BC-1:0] write_strobe;
  // read request channel
  logic          read_request_valid;
  logic          read_request_ready;
  logic [AW-1:0] read_request_address;
  // read response channel
  logic          read_response_valid;
  logic          read_response_ready;
  logic [DW-1:0] read_response_data;

  // producer/consumer side
  modport master (
    output write_valid, write_address, write_data, write_strobe,
    input  write_ready,
    output read_request_valid, read_request_address,
    input  read_request_ready,
    input  read_response_valid, read_response_data,
    output read_response_ready
  );

  // buffer side
  modport slave (
    input  write_valid, write_address, write_data, write_strobe,
    output write_ready,
    input  read_request_valid, read_request_address,
    output read_request_ready,
    output read_response_valid, read_response_data,
    input  read_response_ready
  );
endinterface

// File: rtl/bram_stream.sv
// Block-RAM buffer with per-slice write strobes, 2-cycle registered read and a
// small response FIFO that absorbs read latency and consumer backpressure.
module bram_stream #(
  parameter int ENTRY_COUNT = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = -1,
  parameter int RESP_DEPTH  = 3
) (
  input logic           clk,
  input logic           reset_n,
  bram_stream_if.slave  bus
);

  localparam int AW = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam int SW = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : DATA_WIDTH;
  localparam int BC = (DATA_WIDTH + SW - 1) / SW;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  // When the address space is exactly filled no range check is needed.
  localparam bit ADDR_FULL = (ENTRY_COUNT == (1 << AW));

  // ---------------------------------------------------------------------------
  // Channel decode
  // ---------------------------------------------------------------------------
  logic                  write_ready_q, write_ready_d;
  logic                  in_flight_q, in_flight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BC-1:0]         wstrb;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collide;
  logic                  rd_ready;
  logic                  resp_valid;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_word;

  assign waddr = bus.write_address;
  assign raddr = bus.read_request_address;
  assign wdata = bus.write_data;
  assign wstrb = bus.write_strobe;

  assign wr_in_range = ADDR_FULL || (32'(waddr) < 32'(ENTRY_COUNT));
  assign rd_in_range = ADDR_FULL || (32'(raddr) < 32'(ENTRY_COUNT));

  // Gate with write_ready_q so the read channel is closed during and right at reset.
  assign rd_ready = write_ready_q &&
                    ((32'(count_q) + 32'(in_flight_q)) < 32'(RESP_DEPTH));

  assign wr_fire = bus.write_valid && write_ready_q;
  assign rd_fire = bus.read_request_valid && rd_ready;
  assign collide = wr_fire && rd_fire && (waddr == raddr);

  assign resp_valid = (count_q != '0);
  assign push       = in_flight_q;
  assign pop        = resp_valid && bus.read_response_ready;

  assign bus.write_ready         = write_ready_q;
  assign bus.read_request_ready  = rd_ready;
  assign bus.read_response_valid = resp_valid;
  assign bus.read_response_data  = resp_valid ? fifo_q[rd_ptr_q] : '0;

  // ---------------------------------------------------------------------------
  // Storage slices: each slice is its own RAM with its own strobe; the last
  // slice may be narrower than SW.
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < BC; s++) begin : g_slice
    localparam int LO = s * SW;
    localparam int W  = ((LO + SW) > DATA_WIDTH) ? (DATA_WIDTH - LO) : SW;

    logic [W-1:0] mem_q [ENTRY_COUNT];
    logic [W-1:0] rd_q;

    // slice write: only strobed, in-range writes touch the array
    always_ff @(posedge clk) begin
      if (wr_fire && wr_in_range && wstrb[s]) begin
        mem_q[waddr] <= wdata[LO +: W];
      end
    end

    // slice read register: write-first on collision, zero for out-of-range reads
    always_ff @(posedge clk) begin
      if (rd_fire) begin
        if (!rd_in_range) begin
          rd_q <= '0;
        end else if (collide && wstrb[s]) begin
          rd_q <= wdata[LO +: W];
        end else begin
          rd_q <= mem_q[raddr];
        end
      end
    end

    assign rd_word[LO +: W] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Response FIFO and control
  // ---------------------------------------------------------------------------

  // next-state for pointers, occupancy and the single read stage
  always_comb begin
    write_ready_d = 1'b1;
    in_flight_d   = rd_fire;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // control state; reset drops any in-flight read and empties the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_ready_q <= 1'b0;
      in_flight_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      write_ready_q <= write_ready_d;
      in_flight_q   <= in_flight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: the read word lands here one edge after the request fires
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= rd_word;
    end
  end

  // The request-ready credit check makes these unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count_q == CW'(RESP_DEPTH))));
  a_credit : assert property (@(posedge clk) disable iff (!reset_n)
    (32'(count_q) + 32'(in_flight_q)) <= 32'(RESP_DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && (count_q == '0)));

endmodule

// File: tb/tb_bram_stream.sv
// Directed bench for bram_stream: default 32-bit instance plus a 36-bit,
// 16-bit-slice, 20-entry instance for strobe and out-of-range behaviour.
module tb_bram_stream;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;
  int   accepted;

  always #5 clk = ~clk;

  bram_stream_if #(.AW(10), .DW(32), .BC(1)) bus_a ();
  bram_stream_if #(.AW(5),  .DW(36), .BC(3)) bus_b ();

  bram_stream #(.ENTRY_COUNT(1024), .DATA_WIDTH(32), .BLOCK_WIDTH(-1), .RESP_DEPTH(3))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  bram_stream #(.ENTRY_COUNT(20), .DATA_WIDTH(36), .BLOCK_WIDTH(16), .RESP_DEPTH(3))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.write_valid = 0; bus_a.write_address = '0; bus_a.write_data = '0; bus_a.write_strobe = '0;
    bus_a.read_request_valid = 0; bus_a.read_request_address = '0; bus_a.read_response_ready = 0;
    bus_b.write_valid = 0; bus_b.write_address = '0; bus_b.write_data = '0; bus_b.write_strobe = '0;
    bus_b.read_request_valid = 0; bus_b.read_request_address = '0; bus_b.read_response_ready = 0;

    // 1. reset and release
    step(); step();
    chk("rst_wready", bus_a.write_ready, 0);
    chk("rst_rqready", bus_a.read_request_ready, 0);
    chk("rst_rvalid", bus_a.read_response_valid, 0);
    chk("rst_rdata", bus_a.read_response_data, 0);
    reset_n = 1;
    #1;
    chk("rel_wready_before_edge", bus_a.write_ready, 0);
    step();
    chk("rel_wready", bus_a.write_ready, 1);
    chk("rel_rqready", bus_a.read_request_ready, 1);
    chk("rel_rvalid", bus_a.read_response_valid, 0);
    chk("rel_b_wready", bus_b.write_ready, 1);

    // 2. write then read with 2-cycle latency
    bus_a.write_valid = 1; bus_a.write_address = 5; bus_a.write_data = 32'hDEADBEEF; bus_a.write_strobe = 1'b1;
    step();
    bus_a.write_valid = 0;
    bus_a.read_request_valid = 1; bus_a.read_request_address = 5;
    step();
    bus_a.read_request_valid = 0;
    chk("t2_valid_lat1", bus_a.read_response_valid, 0);
    step();
    chk("t2_valid_lat2", bus_a.read_response_valid, 1);
    chk("t2_data", bus_a.read_response_data, 32'hDEADBEEF);
    step();
    chk("t2_hold_valid", bus_a.read_response_valid, 1);
    chk("t2_hold_data", bus_a.read_response_data, 32'hDEADBEEF);
    bus_a.read_response_ready = 1;
    step();
    chk("t2_popped", bus_a.read_response_valid, 0);
    bus_a.read_response_ready = 0;

    // 3. sliced strobes on the 36-bit instance
    bus_b.read_response_ready = 1;
    bus_b.write_valid = 1; bus_b.write_address = 1; bus_b.write_data = 36'hF_FFFF_FFFF; bus_b.write_strobe = 3'b111;
    step();
    bus_b.write_data = 36'h0; bus_b.write_strobe = 3'b010;
    step();
    bus_b.write_valid = 0;
    bus_b.read_request_valid = 1; bus_b.read_request_address = 1;
    step();
    bus_b.read_request_valid = 0;
    step();
    chk("t3_valid", bus_b.read_response_valid, 1);
    chk("t3_data", bus_b.read_response_data, 36'hF_0000_FFFF);
    bus_b.write_valid = 1; bus_b.write_address = 1; bus_b.write_data = 36'h5_0000_0000; bus_b.write_strobe = 3'b100;
    step();
    bus_b.write_valid = 0;
    chk("t3_popped", bus_b.read_response_valid, 0);
    bus_b.read_request_valid = 1; bus_b.read_request_address = 1;
    step();
    bus_b.read_request_valid = 0;
    step();
    chk("t3_top_slice", bus_b.read_response_data, 36'h5_0000_FFFF);
    step();
    // out of range: write accepted and ignored, read returns 0
    bus_b.write_valid = 1; bus_b.write_address = 25; bus_b.write_data = 36'h7_7777_7777; bus_b.write_strobe = 3'b111;
    chk("oor_wready", bus_b.write_ready, 1);
    step();
    bus_b.write_valid = 0;
    bus_b.read_request_valid = 1; bus_b.read_request_address = 25;
    chk("oor_rqready", bus_b.read_request_ready, 1);
    step();
    bus_b.read_request_valid = 0;
    step();
    chk("oor_valid", bus_b.read_response_valid, 1);
    chk("oor_data", bus_b.read_response_data, 0);
    step();
    // collision with partial strobe
    bus_b.write_valid = 1; bus_b.write_address = 3; bus_b.write_data = 36'h1_2222_3333; bus_b.write_strobe = 3'b111;
    step();
    bus_b.write_data = 36'hA_BBBB_CCCC; bus_b.write_strobe = 3'b101;
    bus_b.read_request_valid = 1; bus_b.read_request_address = 3;
    step();
    bus_b.write_valid = 0; bus_b.read_request_valid = 0;
    step();
    chk("coll_partial", bus_b.read_response_data, 36'hA_2222_CCCC);
    step();

    // 4. same-edge write and read, full strobe
    bus_a.write_valid = 1; bus_a.write_address = 9; bus_a.write_data = 32'hAAAA; bus_a.write_strobe = 1'b1;
    step();
    bus_a.write_data = 32'h1234;
    bus_a.read_request_valid = 1; bus_a.read_request_address = 9;
    step();
    bus_a.write_valid = 0; bus_a.read_request_valid = 0;
    step();
    chk("t4_valid", bus_a.read_response_valid, 1);
    chk("t4_data", bus_a.read_response_data, 32'h1234);
    bus_a.read_response_ready = 1;
    step();
    bus_a.read_response_ready = 0;

    // 5. backpressure: preload 10..14 with 110..114
    for (int i = 0; i < 5; i++) begin
      bus_a.write_valid = 1; bus_a.write_address = 10'(10 + i); bus_a.write_data = 32'(110 + i);
      step();
    end
    bus_a.write_valid = 0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      bus_a.read_request_valid = 1;
      bus_a.read_request_address = 10'(10 + accepted);
      if (bus_a.read_request_ready) accepted++;
      step();
    end
    bus_a.read_request_valid = 0;
    chk("t5_accepted", 64'(accepted), 3);
    chk("t5_rqready_full", bus_a.read_request_ready, 0);
    chk("t5_head0", bus_a.read_response_data, 110);
    bus_a.read_response_ready = 1;
    step();
    chk("t5_head1", bus_a.read_response_data, 111);
    step();
    chk("t5_head2", bus_a.read_response_data, 112);
    step();
    chk("t5_empty", bus_a.read_response_valid, 0);
    // streaming: one read per cycle
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus_a.read_request_valid = 1; bus_a.read_request_address = 10'(10 + i);
        chk("t5_stream_rqready", bus_a.read_request_ready, 1);
      end else begin
        bus_a.read_request_valid = 0;
      end
      if (i >= 2) begin
        chk("t5_stream_valid", bus_a.read_response_valid, 1);
        chk("t5_stream_data", bus_a.read_response_data, 64'(110 + i - 2));
      end
      step();
    end
    chk("t5_stream_drained", bus_a.read_response_valid, 0);
    bus_a.read_response_ready = 0;

    // 6. reset with reads in flight
    bus_a.read_request_valid = 1; bus_a.read_request_address = 5;
    step();
    bus_a.read_request_address = 9;
    step();
    bus_a.read_request_valid = 0;
    #2;
    reset_n = 0;
    #1;
    chk("t6_rst_rvalid", bus_a.read_response_valid, 0);
    chk("t6_rst_rdata", bus_a.read_response_data, 0);
    chk("t6_rst_rqready", bus_a.read_request_ready, 0);
    chk("t6_rst_wready", bus_a.write_ready, 0);
    step(); step();
    reset_n = 1;
    bus_a.read_response_ready = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_stale", bus_a.read_response_valid, 0);
      step();
    end
    bus_a.read_request_valid = 1; bus_a.read_request_address = 5;
    step();
    bus_a.read_request_address = 9;
    step();
    bus_a.read_request_valid = 0;
    chk("t6_keep5", bus_a.read_response_data, 32'hDEADBEEF);
    step();
    chk("t6_keep9", bus_a.read_response_data, 32'h1234);
    step();
    bus_b.read_request_valid = 1; bus_b.read_request_address = 1;
    step();
    bus_b.read_request_valid = 0;
    step();
    chk("t6_keep_b", bus_b.read_response_data, 36'h5_0000_FFFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
